// File: rtl/sru_multi_ch.sv
// Multi-channel synaptic response unit.
// Each accepted tick decays the four postsynaptic traces once, then sweeps
// the presynaptic channels in order, fetching each spiking channel's weight
// from an external memory (one-cycle read latency) and accumulating it into
// the excitatory or inhibitory trace pair. done marks final traces.
//
// Weight memory handshake: w_rd_en/w_addr are asserted for one cycle and the
// memory returns w_data on the following cycle; there is no backpressure.
module sru_multi_ch #(
  parameter int N_CH     = 16,
  parameter int W_WIDTH  = 16,
  parameter int TR_WIDTH = 16,
  parameter int W_SHIFT  = 5,
  parameter int EP_DECAY = 2,
  parameter int EM_DECAY = 3,
  parameter int IP_DECAY = 2,
  parameter int IM_DECAY = 1,
  parameter int SATURATE = 1,
  parameter int ADDR_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tick,
  input  logic                clr,
  input  logic [N_CH-1:0]     spike_vec,
  input  logic [N_CH-1:0]     exc_mask,
  output logic                w_rd_en,
  output logic [ADDR_W-1:0]   w_addr,
  input  logic [W_WIDTH-1:0]  w_data,
  output logic [TR_WIDTH-1:0] ES_plus,
  output logic [TR_WIDTH-1:0] ES_minus,
  output logic [TR_WIDTH-1:0] IS_plus,
  output logic [TR_WIDTH-1:0] IS_minus,
  output logic                busy,
  output logic                done,
  output logic                tick_miss,
  output logic                sat_flag,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_DECAY, S_SWEEP, S_DONE} state_e;

  // Sum is formed wide enough that neither the shift nor the add can overflow.
  localparam int                 SUM_W  = TR_WIDTH + W_WIDTH + W_SHIFT;
  localparam logic [TR_WIDTH-1:0] TR_MAX = '1;
  localparam logic [ADDR_W-1:0]  LAST_K = ADDR_W'(N_CH - 1);
  localparam logic [ADDR_W-1:0]  ONE_K  = ADDR_W'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   k_q, k_d, k_next;
  logic [N_CH-1:0]     spike_q, spike_d, exc_q, exc_d;
  logic [TR_WIDTH-1:0] ep_q, ep_d, em_q, em_d, ip_q, ip_d, im_q, im_d;
  logic                sat_q, sat_d;
  logic [TR_WIDTH:0]   add_a, add_b;

  // Exponential decay step; tr >> sh never exceeds tr, so no underflow.
  function automatic logic [TR_WIDTH-1:0] decay(input logic [TR_WIDTH-1:0] tr,
                                                input int sh);
    return tr - (tr >> sh);
  endfunction

  // Returns {clamped, result}; clamped is only ever set in saturating mode.
  function automatic logic [TR_WIDTH:0] acc_add(input logic [TR_WIDTH-1:0] tr,
                                                input logic [W_WIDTH-1:0] w);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(tr) + (SUM_W'(w) << W_SHIFT);
    if ((SATURATE != 0) && (sum > SUM_W'(TR_MAX)))
      return {1'b1, TR_MAX};
    return {1'b0, sum[TR_WIDTH-1:0]};
  endfunction

  // State, sweep counter, latched vectors, traces and sticky flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      spike_q <= '0;
      exc_q   <= '0;
      ep_q    <= '0;
      em_q    <= '0;
      ip_q    <= '0;
      im_q    <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      spike_q <= spike_d;
      exc_q   <= exc_d;
      ep_q    <= ep_d;
      em_q    <= em_d;
      ip_q    <= ip_d;
      im_q    <= im_d;
      sat_q   <= sat_d;
    end
  end

  assign k_next = k_q + ONE_K;

  // Next-state, trace update and weight-read request.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    spike_d = spike_q;
    exc_d   = exc_q;
    ep_d    = ep_q;
    em_d    = em_q;
    ip_d    = ip_q;
    im_d    = im_q;
    sat_d   = sat_q;
    add_a   = '0;
    add_b   = '0;
    w_rd_en = 1'b0;
    w_addr  = '0;
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          spike_d = spike_vec;
          exc_d   = exc_mask;
          state_d = S_DECAY;
        end else if (clr) begin
          ep_d = '0;
          em_d = '0;
          ip_d = '0;
          im_d = '0;
        end
      end
      S_DECAY: begin
        ep_d    = decay(ep_q, EP_DECAY);
        em_d    = decay(em_q, EM_DECAY);
        ip_d    = decay(ip_q, IP_DECAY);
        im_d    = decay(im_q, IM_DECAY);
        w_addr  = '0;
        w_rd_en = spike_q[0];
        k_d     = '0;
        state_d = S_SWEEP;
      end
      S_SWEEP: begin
        // w_data here answers the read issued in the previous cycle.
        if (spike_q[k_q]) begin
          if (exc_q[k_q]) begin
            add_a = acc_add(ep_q, w_data);
            add_b = acc_add(em_q, w_data);
            ep_d  = add_a[TR_WIDTH-1:0];
            em_d  = add_b[TR_WIDTH-1:0];
          end else begin
            add_a = acc_add(ip_q, w_data);
            add_b = acc_add(im_q, w_data);
            ip_d  = add_a[TR_WIDTH-1:0];
            im_d  = add_b[TR_WIDTH-1:0];
          end
          sat_d = sat_q | add_a[TR_WIDTH] | add_b[TR_WIDTH];
        end
        if (k_q == LAST_K) begin
          state_d = S_DONE;
        end else begin
          w_addr  = k_next;
          w_rd_en = spike_q[k_next];
          k_d     = k_next;
        end
      end
      S_DONE: begin
        k_d     = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign tick_miss = tick & busy;
  assign sat_flag  = sat_q;
  assign ES_plus   = ep_q;
  assign ES_minus  = em_q;
  assign IS_plus   = ip_q;
  assign IS_minus  = im_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sru_multi_ch.sv
// Bench for sru_multi_ch: a saturating and a wrapping instance (N_CH=4)
// share stimulus; each has its own one-cycle-latency weight memory responder.
module tb_sru_multi_ch;

  logic        clk = 1'b0;
  logic        reset_n, tick, clr;
  logic [3:0]  spike_vec, exc_mask;
  logic [15:0] wmem [4];

  logic        s_rd_en, s_busy, s_done, s_miss, s_sat;
  logic [1:0]  s_addr, s_state;
  logic [15:0] s_wdata, s_ep, s_em, s_ip, s_im;
  logic        x_rd_en, x_busy, x_done, x_miss, x_sat;
  logic [1:0]  x_addr, x_state;
  logic [15:0] x_wdata, x_ep, x_em, x_ip, x_im;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: [0]=saturating instance, [1]=wrapping instance.
  longint m_tr [2][4];
  bit     m_sat [2];
  int     decay_sh [4] = '{2, 3, 2, 1};
  logic [63:0] exp_q[$];

  typedef struct {
    bit          do_clr;
    logic [3:0]  sp;
    logic [3:0]  ex;
    logic [63:0] w;      // {w3, w2, w1, w0}
    logic [15:0] e_ep, e_em, e_ip, e_im;
    bit          e_sat;
  } vec_t;
  vec_t tbl [7];

  sru_multi_ch #(.N_CH(4), .SATURATE(1)) dut_sat (
    .clk(clk), .reset_n(reset_n), .tick(tick), .clr(clr),
    .spike_vec(spike_vec), .exc_mask(exc_mask),
    .w_rd_en(s_rd_en), .w_addr(s_addr), .w_data(s_wdata),
    .ES_plus(s_ep), .ES_minus(s_em), .IS_plus(s_ip), .IS_minus(s_im),
    .busy(s_busy), .done(s_done), .tick_miss(s_miss), .sat_flag(s_sat),
    .dbg_state(s_state)
  );

  sru_multi_ch #(.N_CH(4), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .tick(tick), .clr(clr),
    .spike_vec(spike_vec), .exc_mask(exc_mask),
    .w_rd_en(x_rd_en), .w_addr(x_addr), .w_data(x_wdata),
    .ES_plus(x_ep), .ES_minus(x_em), .IS_plus(x_ip), .IS_minus(x_im),
    .busy(x_busy), .done(x_done), .tick_miss(x_miss), .sat_flag(x_sat),
    .dbg_state(x_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Weight memories: data one cycle after a read, garbage otherwise.
  always @(posedge clk) begin
    s_wdata <= s_rd_en ? wmem[s_addr] : 16'($urandom);
    x_wdata <= x_rd_en ? wmem[x_addr] : 16'($urandom);
  end

  // Absolute time limit.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic void model_clr();
    for (int d = 0; d < 2; d++)
      for (int t = 0; t < 4; t++) m_tr[d][t] = 0;
  endfunction

  function automatic void model_reset();
    model_clr();
    m_sat[0] = 1'b0;
    m_sat[1] = 1'b0;
  endfunction

  // One timestep: divide-based decay, then add each spiking weight x32.
  function automatic void model_tick(input logic [3:0] sp, input logic [3:0] ex);
    longint v;
    for (int d = 0; d < 2; d++) begin
      for (int t = 0; t < 4; t++)
        m_tr[d][t] = m_tr[d][t] - m_tr[d][t] / (longint'(1) << decay_sh[t]);
      for (int ch = 0; ch < 4; ch++) begin
        if (sp[ch]) begin
          for (int t = 0; t < 4; t++) begin
            if ((t < 2) == (ex[ch] == 1'b1)) begin
              v = m_tr[d][t] + longint'(wmem[ch]) * 32;
              if (v > 65535) begin
                if (d == 0) begin
                  v = 65535;
                  m_sat[0] = 1'b1;
                end else begin
                  v = v % 65536;
                end
              end
              m_tr[d][t] = v;
            end
          end
        end
      end
    end
  endfunction

  task automatic check_traces(input string tag);
    check({tag, " s_ES_plus"},  s_ep,  m_tr[0][0]);
    check({tag, " s_ES_minus"}, s_em,  m_tr[0][1]);
    check({tag, " s_IS_plus"},  s_ip,  m_tr[0][2]);
    check({tag, " s_IS_minus"}, s_im,  m_tr[0][3]);
    check({tag, " s_sat_flag"}, s_sat, m_sat[0]);
    check({tag, " x_ES_plus"},  x_ep,  m_tr[1][0]);
    check({tag, " x_ES_minus"}, x_em,  m_tr[1][1]);
    check({tag, " x_IS_plus"},  x_ip,  m_tr[1][2]);
    check({tag, " x_IS_minus"}, x_im,  m_tr[1][3]);
    check({tag, " x_sat_flag"}, x_sat, m_sat[1]);
  endtask

  task automatic do_clr();
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_clr();
    @(negedge clk);
    check_traces("clr_idle");
  endtask

  // Issue one tick and follow it cycle by cycle until done. poke_at>0
  // re-asserts tick and clr in that cycle of the sweep.
  task automatic run_tick(input logic [3:0] sp, input logic [3:0] ex,
                          input int poke_at, input string tag);
    int done_cyc;
    logic [63:0] exp_tr;
    done_cyc = 0;
    model_tick(sp, ex);
    exp_q.push_back({16'(m_tr[0][0]), 16'(m_tr[0][1]), 16'(m_tr[0][2]), 16'(m_tr[0][3])});
    @(posedge clk); #1;
    tick = 1'b1;
    spike_vec = sp;
    exc_mask = ex;
    @(negedge clk);
    check({tag, " busy@0"}, s_busy, 0);
    check({tag, " miss@0"}, s_miss, 0);
    @(posedge clk); #1;
    tick = 1'b0;
    spike_vec = 4'($urandom);
    exc_mask = 4'($urandom);
    for (int c = 1; c <= 10 && done_cyc == 0; c++) begin
      if (c == poke_at) begin
        tick = 1'b1;
        clr = 1'b1;
      end
      @(negedge clk);
      check($sformatf("%s busy@%0d", tag, c), s_busy, (c <= 6) ? 1 : 0);
      check($sformatf("%s done@%0d", tag, c), s_done, (c == 6) ? 1 : 0);
      check($sformatf("%s xdone@%0d", tag, c), x_done, (c == 6) ? 1 : 0);
      check($sformatf("%s miss@%0d", tag, c), s_miss, (c == poke_at) ? 1 : 0);
      check($sformatf("%s rd_en@%0d", tag, c), s_rd_en,
            (c >= 1 && c <= 4) ? sp[c-1] : 1'b0);
      if (c <= 4) check($sformatf("%s addr@%0d", tag, c), s_addr, c - 1);
      if (s_done === 1'b1) done_cyc = c;
      @(posedge clk); #1;
      tick = 1'b0;
      clr = 1'b0;
    end
    check({tag, " latency"}, done_cyc, 6);
    exp_tr = exp_q.pop_front();
    check({tag, " packed_traces"}, {s_ep, s_em, s_ip, s_im}, exp_tr);
    check_traces(tag);
  endtask

  initial begin
    tbl[0] = '{1'b1, 4'b0001, 4'b0001, 64'h0000_0000_0000_0003, 16'd96, 16'd96, 16'd0, 16'd0, 1'b0};
    tbl[1] = '{1'b0, 4'b0000, 4'b0000, 64'h0000_0000_0000_0003, 16'd72, 16'd84, 16'd0, 16'd0, 1'b0};
    tbl[2] = '{1'b1, 4'b0001, 4'b0000, 64'h0000_0000_0000_0003, 16'd0, 16'd0, 16'd96, 16'd96, 1'b0};
    tbl[3] = '{1'b0, 4'b0000, 4'b0000, 64'h0000_0000_0000_0003, 16'd0, 16'd0, 16'd72, 16'd48, 1'b0};
    tbl[4] = '{1'b1, 4'b1111, 4'b0011, 64'h0004_0003_0002_0001, 16'd96, 16'd96, 16'd224, 16'd224, 1'b0};
    tbl[5] = '{1'b1, 4'b0001, 4'b0001, 64'h0000_0000_0000_FFFF, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0, 1'b1};
    tbl[6] = '{1'b0, 4'b0000, 4'b0000, 64'h0000_0000_0000_FFFF, 16'd49152, 16'd57344, 16'd0, 16'd0, 1'b1};

    // Reset.
    reset_n = 1'b0;
    tick = 1'b0;
    clr = 1'b0;
    spike_vec = '0;
    exc_mask = '0;
    for (int k = 0; k < 4; k++) wmem[k] = '0;
    model_reset();
    #12;
    check("rst ES_plus", s_ep, 0);
    check("rst IS_minus", s_im, 0);
    check("rst busy", s_busy, 0);
    check("rst done", s_done, 0);
    check("rst w_rd_en", s_rd_en, 0);
    check("rst w_addr", s_addr, 0);
    check("rst sat_flag", s_sat, 0);
    check("rst state", s_state, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 4; k++) wmem[k] = tbl[i].w[k*16 +: 16];
      if (tbl[i].do_clr) do_clr();
      run_tick(tbl[i].sp, tbl[i].ex, 0, $sformatf("row%0d", i));
      check($sformatf("row%0d ES_plus", i), s_ep, tbl[i].e_ep);
      check($sformatf("row%0d ES_minus", i), s_em, tbl[i].e_em);
      check($sformatf("row%0d IS_plus", i), s_ip, tbl[i].e_ip);
      check($sformatf("row%0d IS_minus", i), s_im, tbl[i].e_im);
      check($sformatf("row%0d sat_flag", i), s_sat, tbl[i].e_sat);
      if (i == 5) begin
        check("row5 wrap ES_plus", x_ep, 16'hFFE0);
        check("row5 wrap sat_flag", x_sat, 0);
      end
    end

    // Tick and clr while busy: tick_miss pulse, sweep unaffected.
    do_clr();
    wmem[0] = 16'd3;
    run_tick(4'b0001, 4'b0001, 3, "poke");
    check("poke ES_plus", s_ep, 96);
    check("poke IS_plus", s_ip, 0);

    // Asynchronous reset in the middle of a sweep.
    @(posedge clk); #1;
    tick = 1'b1;
    spike_vec = 4'b0001;
    exc_mask = 4'b0001;
    @(posedge clk); #1;
    tick = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("midrst ES_plus", s_ep, 0);
    check("midrst ES_minus", s_em, 0);
    check("midrst IS_plus", s_ip, 0);
    check("midrst busy", s_busy, 0);
    check("midrst done", s_done, 0);
    check("midrst w_rd_en", s_rd_en, 0);
    check("midrst sat_flag", s_sat, 0);
    check("midrst state", s_state, 0);
    check("midrst wrap ES_plus", x_ep, 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    run_tick(4'b0001, 4'b0001, 0, "post_rst");
    check("post_rst ES_plus", s_ep, 96);
    check("post_rst ES_minus", s_em, 96);

    // Randomized timesteps against the model.
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < 4; k++)
        wmem[k] = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2047));
      if ($urandom_range(0, 3) == 0) do_clr();
      run_tick(4'($urandom), 4'($urandom),
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0,
               $sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sru_multi_ch.md
Name: sru_multi_ch

Overview:
- Parametrised multi-channel successor of the single-input synaptic response unit.
- Once per simulation timestep (tick), all four postsynaptic traces (ES_plus, ES_minus, IS_plus, IS_minus) decay exactly once. The block then sweeps N_CH presynaptic channels, fetching each spiking channel's weight from an external weight memory and adding it into the excitatory or inhibitory trace pair.
- Sits between the spike-vector register and the LIF neuron core; the neuron samples the traces on done.

Parameters:
N_CH, 16, number of presynaptic channels (>=1)
W_WIDTH, 16, weight word width (unsigned)
TR_WIDTH, 16, trace register width (unsigned)
W_SHIFT, 5, left shift applied to weight before accumulation
EP_DECAY, 2, ES_plus decay shift (tr - tr>>EP_DECAY)
EM_DECAY, 3, ES_minus decay shift
IP_DECAY, 2, IS_plus decay shift
IM_DECAY, 1, IS_minus decay shift
SATURATE, 1, 1 = clamp adds at 2^TR_WIDTH-1; 0 = modulo wrap
ADDR_W, max(1,$clog2(N_CH)), weight address width

Ports:
clk  in  1  clock; all registers update on rising edge
reset_n  in  1  asynchronous, active-low reset
tick  in  1  timestep strobe, one-cycle pulse
clr  in  1  synchronous trace clear, honoured only in IDLE
spike_vec  in  N_CH  per-channel spike bits, sampled on accepted tick
exc_mask  in  N_CH  1 = excitatory channel, 0 = inhibitory; sampled with spike_vec
w_rd_en  out  1  weight memory read strobe
w_addr  out  ADDR_W  weight address = channel index
w_data  in  W_WIDTH  read data, valid exactly 1 cycle after w_rd_en
ES_plus, ES_minus, IS_plus, IS_minus  out  TR_WIDTH each  trace registers
busy  out  1  high from DECAY through DONE
done  out  1  one-cycle pulse; traces final for this timestep
tick_miss  out  1  one-cycle pulse when tick arrives while busy
sat_flag  out  1  sticky; set on any clamped add, cleared only by reset

Behaviour:
- Reset (async, reset_n=0): all traces 0, busy/done/tick_miss/sat_flag/w_rd_en 0, w_addr 0, state IDLE, channel counter 0. Reset mid-sweep aborts the sweep; no partial result is kept.
- FSM states: IDLE, DECAY, SWEEP, DONE.
- IDLE:
  - tick=1: latch spike_vec and exc_mask into internal copies; go to DECAY. tick has priority over clr.
  - clr=1 with tick=0: all traces <= 0 for one cycle.
- DECAY (cycle T+1 for tick at T):
  - All four traces <= tr - (tr >> shift).
  - Issue a read for channel 0: w_addr=0, w_rd_en=spike[0].
  - Go to SWEEP with k=0.
- SWEEP, cycle T+2+k, k = 0..N_CH-1:
  - If spike[k], add c = w_data << W_SHIFT, computed at TR_WIDTH+W_WIDTH+W_SHIFT bits, to ES_plus and ES_minus if exc[k], else to IS_plus and IS_minus.
  - If k < N_CH-1, issue w_addr=k+1, w_rd_en=spike[k+1].
  - After k=N_CH-1, go to DONE.
  - w_rd_en is 0 for non-spiking channels; w_data is ignored in those cycles.
- DONE (T+N_CH+2): done=1 for one cycle, then return to IDLE. Total latency from tick to done is N_CH+2 cycles. busy is high T+1..T+N_CH+2. The next tick is accepted at T+N_CH+3.
- Add rule:
  - SATURATE=1: if tr + c > 2^TR_WIDTH-1, the result is 2^TR_WIDTH-1 and sat_flag <= 1. This includes the case where c alone exceeds the range.
  - SATURATE=0: the result is truncated to TR_WIDTH bits, and sat_flag stays 0.
- Decay never underflows; tr=0 stays 0.
- A tick while busy is dropped: tick_miss=1 for that cycle, and the latched vectors and sweep are unaffected. clr while busy is ignored.
- spike_vec and exc_mask changes after the accepted tick have no effect on the current sweep.

Test Plan:
- N_CH=4, traces 0, tick with spike=0001, exc=0001, w[0]=3 -> done exactly 6 cycles after tick; ES_plus=ES_minus=96, IS_plus=IS_minus=0; w_rd_en high only in the DECAY cycle.
- Continue: tick with spike=0000 -> ES_plus=72, ES_minus=84, w_rd_en never asserted. Then inhibitory w=3 from zero, followed by an empty tick -> IS_plus=72, IS_minus=48.
- spike=1111, exc=0011, w={1,2,3,4} for channels 0..3 -> ES_plus=ES_minus=96, IS_plus=IS_minus=224.
- SATURATE=1, w[0]=16'hFFFF excitatory -> ES_plus=ES_minus=16'hFFFF, sat_flag=1 and still 1 after later ticks. Repeat with SATURATE=0 -> ES_plus=16'hFFE0, sat_flag=0.
- Tick re-asserted at T+3 during a sweep -> tick_miss pulse at T+3, single done at T+6, results identical to the unperturbed run. clr during busy -> no effect; clr in IDLE -> all traces 0 next cycle.
- reset_n pulled low at T+3 mid-sweep -> all outputs 0 immediately (asynchronously), state IDLE. The next tick produces the same result as the first scenario.
